// File: rtl/flash_reader_pkg.sv
// Shared state encoding, default timing and counter sizing for the
// burst flash reader.
package flash_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        OUTPUT,
        RECOVER
    } state_e;

    localparam int DEF_T_SETUP   = 1;
    localparam int DEF_T_ACCESS  = 3;
    localparam int DEF_T_RECOVER = 2;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fr_wait_counter.sv
// Loadable down-counter; last is high on the final cycle of a loaded wait.
module fr_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/flash_burst_reader.sv
// Burst reader for the parallel flash: generates its own wait states and
// packs BPW bytes per word onto a valid/ready output.
module flash_burst_reader
    import flash_reader_pkg::*;
#(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 8,
    parameter int BPW       = 4,
    parameter int LEN_W     = 8,
    parameter int T_SETUP   = DEF_T_SETUP,
    parameter int T_ACCESS  = DEF_T_ACCESS,
    parameter int T_RECOVER = DEF_T_RECOVER
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     flash_addr,
    output logic                  flash_ce_n,
    output logic                  flash_oe_n,
    input  logic [DATA_W-1:0]     flash_rdata,
    output logic [DATA_W*BPW-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready
);

    localparam int CW = cnt_width(T_SETUP, T_ACCESS, T_RECOVER);
    localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        words_q, words_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_W*BPW-1:0]   word_q, word_d;
    logic                    done_q, done_d;
    logic                    cnt_load;
    logic [CW-1:0]           cnt_value;
    logic                    cnt_last;

    fr_wait_counter #(.W(CW)) u_wait (
        .clk   (CLK),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .last  (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        words_d   = words_q;
        idx_d     = idx_q;
        word_d    = word_q;
        done_d    = 1'b0;
        cnt_load  = 1'b0;
        cnt_value = CW'(T_ACCESS);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        addr_d    = start_addr;
                        words_d   = burst_len;
                        idx_d     = '0;
                        state_d   = SETUP;
                        cnt_load  = 1'b1;
                        cnt_value = CW'(T_SETUP);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_d  = ACCESS;
                    cnt_load = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_last) begin
                    word_d[int'(idx_q)*DATA_W +: DATA_W] = flash_rdata;
                    if (idx_q != IW'(BPW - 1)) begin
                        idx_d    = idx_q + IW'(1);
                        addr_d   = addr_q + ADDR_W'(1);
                        cnt_load = 1'b1;
                    end else begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (word_ready) begin
                    words_d  = words_q - LEN_W'(1);
                    addr_d   = addr_q + ADDR_W'(1);
                    idx_d    = '0;
                    cnt_load = 1'b1;
                    if (words_q == LEN_W'(1)) begin
                        state_d   = RECOVER;
                        cnt_value = CW'(T_RECOVER);
                    end else begin
                        state_d   = SETUP;
                        cnt_value = CW'(T_SETUP);
                    end
                end
            end
            RECOVER: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign flash_addr = addr_q;
    assign flash_ce_n = !((state_q == SETUP) || (state_q == ACCESS));
    assign flash_oe_n = (state_q != ACCESS);
    assign word_data  = word_q;
    assign word_valid = (state_q == OUTPUT);

endmodule

// File: tb/tb_flash_burst_reader.sv
// Randomised and directed bench for flash_burst_reader against a
// timeline model of the burst.
module tb_flash_burst_reader;

    localparam int AW  = 23;
    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int LW  = 8;
    localparam int TS  = 1;
    localparam int TA  = 3;
    localparam int TR  = 2;
    localparam int SEG_LEN = TS + BPW * TA;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     start_addr;
    logic [LW-1:0]     burst_len;
    logic              busy;
    logic              done;
    logic [AW-1:0]     flash_addr;
    logic              flash_ce_n;
    logic              flash_oe_n;
    logic [DW-1:0]     flash_rdata;
    logic [DW*BPW-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    always #5 clk = ~clk;

    // flash contents: each byte holds the low byte of its address
    assign flash_rdata = flash_addr[7:0];

    flash_burst_reader dut (
        .CLK         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .burst_len   (burst_len),
        .busy        (busy),
        .done        (done),
        .flash_addr  (flash_addr),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_rdata (flash_rdata),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef enum int {P_IDLE, P_SEG, P_OUT, P_REC} ph_t;
    ph_t           ph = P_IDLE;
    int            k = 0;
    logic [AW-1:0] base = '0;
    int            left = 0;
    bit            wzero = 1'b1;
    logic [AW-1:0] e_addr = '0;
    bit            e_done = 1'b0;

    int            bt, fv, gap, done_at, dones, xfers;
    bit            ce_low, valid_seen, prev_valid;
    logic [31:0]   first_word;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [AW-1:0] a);
        logic [31:0] w;
        logic [AW-1:0] b;
        for (int i = 0; i < BPW; i++) begin
            b = a + AW'(i);
            w[i*DW +: DW] = b[7:0];
        end
        return w;
    endfunction

    task automatic model_edge(input bit rst, input bit st, input bit rdy,
                              input logic [AW-1:0] sa,
                              input logic [LW-1:0] bl);
        e_done = 1'b0;
        if (rst) begin
            ph = P_IDLE;
            e_addr = '0;
            wzero = 1'b1;
        end else begin
            case (ph)
                P_IDLE: if (st) begin
                    if (bl != 0) begin
                        base = sa; left = int'(bl); k = 0;
                        ph = P_SEG; wzero = 1'b0;
                    end else begin
                        e_done = 1'b1;
                    end
                end
                P_SEG: begin
                    k++;
                    if (k == SEG_LEN) ph = P_OUT;
                end
                P_OUT: if (rdy) begin
                    left--;
                    base = base + AW'(BPW);
                    k = 0;
                    ph = (left == 0) ? P_REC : P_SEG;
                end
                P_REC: begin
                    k++;
                    if (k == TR) begin
                        ph = P_IDLE;
                        e_done = 1'b1;
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        case (ph)
            P_SEG:   e_addr = (k < TS) ? base : base + AW'((k - TS) / TA);
            P_OUT:   e_addr = base + AW'(BPW - 1);
            P_REC:   e_addr = base;
            default: e_addr = e_addr;
        endcase
    endtask

    task automatic compare();
        chk("busy", busy, ph != P_IDLE);
        chk("done", done, e_done);
        chk("ce_n", flash_ce_n, ph != P_SEG);
        chk("oe_n", flash_oe_n, !(ph == P_SEG && k >= TS));
        chk("word_valid", word_valid, ph == P_OUT);
        chk("flash_addr", flash_addr, e_addr);
        if (ph == P_OUT)
            chk("word_data", word_data, pack(base));
        else if (wzero)
            chk("word_data_rst", word_data, 0);
    endtask

    task automatic tick();
        bit rst_s, st_s, rdy_s, px;
        logic [AW-1:0] sa_s;
        logic [LW-1:0] bl_s;
        logic [31:0] pw;
        rst_s = reset; st_s = start; rdy_s = word_ready;
        sa_s = start_addr; bl_s = burst_len;
        px = word_valid && word_ready;
        pw = word_data;
        @(posedge clk);
        #1;
        cyc++;
        bt++;
        model_edge(rst_s, st_s, rdy_s, sa_s, bl_s);
        compare();
        if (px) begin
            if (xfers == 0) first_word = pw;
            xfers++;
        end
        if (word_valid && !prev_valid) begin
            if (fv < 0) fv = bt;
            else if (gap < 0) gap = bt - fv;
        end
        prev_valid = word_valid;
        if (word_valid) valid_seen = 1'b1;
        if (!flash_ce_n) ce_low = 1'b1;
        if (done) begin
            dones++;
            if (done_at < 0) done_at = bt;
        end
    endtask

    task automatic clear_stats();
        bt = 0; fv = -1; gap = -1; done_at = -1; dones = 0; xfers = 0;
        ce_low = 0; valid_seen = 0; first_word = '0;
    endtask

    task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] n,
                         input int pct, input bit inject,
                         input int stall_word, input int stall_n);
        int guard;
        int sl;
        sl = stall_n;
        guard = 0;
        clear_stats();
        start = 1'b1; start_addr = a; burst_len = n;
        word_ready = ($urandom_range(0, 99) < pct);
        tick();
        start = 1'b0;
        while (ph != P_IDLE && guard < 4000) begin
            if (stall_word > 0 && word_valid && xfers == stall_word - 1
                && sl > 0) begin
                word_ready = 1'b0;
                sl--;
            end else begin
                word_ready = ($urandom_range(0, 99) < pct);
            end
            if (inject && (ph == P_SEG || ph == P_OUT)
                && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                start_addr = AW'($urandom);
                burst_len = LW'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            tick();
            guard++;
        end
        start = 1'b0;
        if (guard >= 4000)
            chk("burst_timeout", guard, 0);
        word_ready = 1'b0;
        tick();
        tick();
        chk("xfer_count", xfers, n);
        chk("done_count", dones, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0;
        burst_len = '0; word_ready = 1'b0;
        prev_valid = 1'b0;
        clear_stats();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        burst(23'h000100, 8'd1, 100, 1'b0, 0, 0);
        chk("single_first_valid_cycle", fv, 14);
        chk("single_word", first_word, 32'h03020100);
        chk("single_done_cycle", done_at, 17);
        chk("single_busy_after", busy, 0);

        burst(23'h002000, 8'd3, 100, 1'b0, 2, 5);
        chk("stall_valid_seen", valid_seen, 1);

        burst(23'h000040, 8'd2, 100, 1'b0, 0, 0);
        chk("word_gap", gap, 14);
        chk("gap_first_word", first_word, 32'h43424140);

        burst(23'h000055, 8'd0, 100, 1'b0, 0, 0);
        chk("zero_done_cycle", done_at, 1);
        chk("zero_ce_low", ce_low, 0);
        chk("zero_valid", valid_seen, 0);

        burst(23'h7FFFFE, 8'd1, 100, 1'b0, 0, 0);
        chk("wrap_word", first_word, 32'h0100FFFE);
        chk("wrap_addr_after", flash_addr, 23'h000002);

        clear_stats();
        start = 1'b1; start_addr = 23'h000500; burst_len = 8'd2;
        word_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 50; g++) begin
            if (ph == P_SEG && k >= TS + TA) break;
            tick();
        end
        chk("mid_in_second_byte", flash_addr, 23'h000501);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_ce_n", flash_ce_n, 1);
        chk("rst_busy", busy, 0);
        dones = 0;
        repeat (5) tick();
        chk("rst_no_done", dones, 0);
        burst(23'h000600, 8'd1, 100, 1'b0, 0, 0);
        chk("after_rst_word", first_word, 32'h03020100);

        burst(23'h003000, 8'd3, 70, 1'b1, 0, 0);

        for (int r = 0; r < 15; r++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? AW'(23'h7FFFFC + $urandom_range(0, 3))
                                             : AW'($urandom);
            burst(ra, LW'($urandom_range(0, 4)), $urandom_range(30, 100),
                  1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
